// File: rtl/alu8_pkg.sv
// Shared types and constants for the two-port ALU8 arbiter.
package alu8_pkg;

  localparam int unsigned DW  = 8;
  localparam int unsigned PW  = 16;
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_INV  = 4'd0;
  localparam logic [OPW-1:0] OP_AND  = 4'd1;
  localparam logic [OPW-1:0] OP_OR   = 4'd2;
  localparam logic [OPW-1:0] OP_SLL  = 4'd3;
  localparam logic [OPW-1:0] OP_SRL  = 4'd4;
  localparam logic [OPW-1:0] OP_SLA  = 4'd5;
  localparam logic [OPW-1:0] OP_SRA  = 4'd6;
  localparam logic [OPW-1:0] OP_ROL  = 4'd7;
  localparam logic [OPW-1:0] OP_ROR  = 4'd8;
  localparam logic [OPW-1:0] OP_ADD  = 4'd9;
  localparam logic [OPW-1:0] OP_SUB  = 4'd10;
  localparam logic [OPW-1:0] OP_MUL  = 4'd11;
  localparam logic [OPW-1:0] OP_ZERO = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Response payload captured from the ALU (or synthesised for an illegal op).
  typedef struct packed {
    logic [DW-1:0] result;
    logic [PW-1:0] product;
    logic          of;
    logic          zero;
    logic          slt;
    logic          err;
  } rsp_t;

  // Opcodes 12-14 have no ALU function and are answered with an error.
  function automatic logic is_legal_op(input logic [OPW-1:0] op);
    return !(op inside {4'd12, 4'd13, 4'd14});
  endfunction

endpackage

// File: rtl/alu8_arbiter_if.sv
// Request/response bus between the requesters and the ALU8 arbiter.
interface alu8_arbiter_if;
  import alu8_pkg::*;

  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0][DW-1:0]      req_a;
  logic [1:0][DW-1:0]      req_b;
  logic [1:0][OPW-1:0]     req_op;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_id;
  logic [DW-1:0]           rsp_result;
  logic [PW-1:0]           rsp_product;
  logic                    rsp_of;
  logic                    rsp_zero;
  logic                    rsp_slt;
  logic                    rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_product,
           rsp_of, rsp_zero, rsp_slt, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_product,
           rsp_of, rsp_zero, rsp_slt, rsp_err
  );

endinterface

// File: rtl/alu8_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to rr_ptr.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = valid;
    if (valid == 2'b11) begin
      grant_c = rr_ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu8_arbiter.sv
// Shares one ALU8 between two requesters: round-robin accept, hold operands
// for the op latency, then return the captured result over valid/ready.
module alu8_arbiter
  import alu8_pkg::*;
#(
  parameter int unsigned LAT_BASIC = 1,
  parameter int unsigned LAT_MUL   = 2,
  parameter int unsigned NUM_REQ   = 2
) (
  input  logic           clk,
  input  logic           rst,
  alu8_arbiter_if.slave  bus,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_result,
  input  logic [PW-1:0]  alu_product,
  input  logic           alu_of,
  input  logic           alu_zero,
  input  logic           alu_slt,
  output logic           busy
);

  localparam int unsigned LAT_MAX = (LAT_MUL > LAT_BASIC) ? LAT_MUL : LAT_BASIC;
  localparam int unsigned CNT_W   = $clog2(LAT_MAX) + 1;

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic               rr_ptr;
  logic               rsp_id_q;
  rsp_t               rsp_q;
  logic [NUM_REQ-1:0] grant_c;
  logic               accept;
  logic               sel_id;
  logic [OPW-1:0]     sel_op;
  logic               sel_legal;

  rr_arb2 u_arb (
    .valid   (bus.req_valid),
    .rr_ptr  (rr_ptr),
    .grant_c (grant_c)
  );

  // Grant is offered only while idle and out of reset; it is the accept itself.
  assign bus.req_ready = (state == IDLE && !rst) ? grant_c : 2'b00;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign sel_id        = grant_c[1];
  assign sel_op        = bus.req_op[sel_id];
  assign sel_legal     = is_legal_op(sel_op);

  assign busy            = (state != IDLE);
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_q.result;
  assign bus.rsp_product = rsp_q.product;
  assign bus.rsp_of      = rsp_q.of;
  assign bus.rsp_zero    = rsp_q.zero;
  assign bus.rsp_slt     = rsp_q.slt;
  assign bus.rsp_err     = rsp_q.err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_legal) begin
            state_n = EXEC;
            cnt_n   = (sel_op == OP_MUL) ? CNT_W'(LAT_MUL - 1) : CNT_W'(LAT_BASIC - 1);
          end else begin
            state_n = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt == '0) state_n = RESP;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      RESP: begin
        if (bus.rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand latch doubles as the ALU drive; alu_op parks on set-zero outside EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_q    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= OP_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id_q <= sel_id;
            if (sel_legal) begin
              alu_a  <= bus.req_a[sel_id];
              alu_b  <= bus.req_b[sel_id];
              alu_op <= sel_op;
            end else begin
              rsp_q     <= '0;
              rsp_q.err <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_q.result  <= alu_result;
            rsp_q.product <= alu_product;
            rsp_q.of      <= alu_of;
            rsp_q.zero    <= alu_zero;
            rsp_q.slt     <= alu_slt;
            rsp_q.err     <= 1'b0;
            alu_op        <= OP_ZERO;
          end
        end
        RESP: begin
          if (bus.rsp_ready) rr_ptr <= ~rsp_id_q;
        end
        default: ;
      endcase
    end
  end

endmodule
